addac_collector: RTL and testbench
==================================

Name: addac_collector

Overview:
- Downstream stage of the serial add/accumulate cell.
- Captures the cell's LSB-first serial sum bit `s` and its final carry `cout` into a parallel WIDTH-bit word plus carry.
- Presents each assembled word on a valid/ready output port.
- Holds one word in the shift register and one in the output register, so the serial producer can continue while the consumer stalls.

Parameters:
WIDTH  4  number of sum bits per frame (≥1)

Ports:
clk        in   1      system clock, all state updates on rising edge
rst        in   1      asynchronous reset, active-high
bit_valid  in   1      s_in/cout_in/bit_sof valid this cycle
bit_sof    in   1      qualifies bit_valid: this bit is bit 0 of a new frame
s_in       in   1      serial sum bit from addac, LSB first
cout_in    in   1      carry from addac; sampled only with the last bit of a frame
word_out   out  WIDTH  assembled sum, bit i = i-th captured bit
carry_out  out  1      cout_in sampled with bit WIDTH-1
word_valid out  1      word_out/carry_out hold a valid result
word_ready in   1      consumer accepts result when word_valid && word_ready
frame_err  out  1      one-cycle pulse on framing error
overrun    out  1      one-cycle pulse when a bit is dropped

Behaviour:
- Reset: asynchronous on rst high, applies immediately and mid-frame.
  - State = IDLE, bit counter = 0, shift register = 0.
  - word_out = 0, carry_out = 0, word_valid = 0, frame_err = 0, overrun = 0.
  - Any partial frame or held word is discarded.
- Capture: a bit is captured on a rising edge with bit_valid=1. Shift register fills LSB first, so bit k lands in position k. Counter ranges 0..WIDTH-1.
- FSM states: IDLE, COLLECT, FULL.
- IDLE:
  - bit_valid && bit_sof: capture bit 0. If WIDTH==1, complete the frame (see completion rule); else go to COLLECT with counter=1.
  - bit_valid && !bit_sof: bit ignored, frame_err pulses, stay in IDLE.
- COLLECT:
  - bit_valid && !bit_sof: capture bit, counter+1.
  - When the captured bit has counter == WIDTH-1: sample cout_in and complete the frame.
  - bit_valid && bit_sof: frame_err pulses. Partial frame is discarded, this bit becomes bit 0 of a new frame, counter=1.
  - No bit_valid: hold; there is no timeout.
- Frame completion, output register free (word_valid=0, or word_valid && word_ready this cycle): load word_out/carry_out, set word_valid next cycle, go to IDLE.
- Frame completion, output register occupied: go to FULL; the word is held in the shift register.
- FULL:
  - Any bit_valid: bit dropped, overrun pulses.
  - When the output register frees (word_valid && word_ready): transfer the held word, keep word_valid=1 next cycle, go to IDLE.
  - A bit_valid && bit_sof in the transfer cycle is still dropped; producer must resend.
- Output handshake:
  - word_valid deasserts the cycle after acceptance unless a new word loads in the same cycle.
  - word_out/carry_out are stable while word_valid=1 && word_ready=0.
- Latency: word_valid rises on the clock edge that captures bit WIDTH-1, visible the following cycle (1 cycle after last bit), when the output register is free.
- Simultaneous events:
  - Acceptance and completion in the same cycle: the new word loads, word_valid stays 1 with no gap.
  - frame_err and overrun are mutually exclusive per cycle.

Optional Feature:
Macro: ADDAC_COLLECTOR_ERRCNT_EN
- Defined:
  - Adds output err_count [7:0], reset to 0.
  - Increments on every frame_err or overrun pulse; saturates at 255.
  - Adds input err_clr, synchronous clear; clear wins over a same-cycle increment.
- Undefined: no err_count port, no err_clr port, no counter logic. All other behaviour is identical.

Test Plan:
- WIDTH=4, word_ready=1: bits 1,0,1,1 (sof on first), cout_in=1 on last → one cycle later word_out=4'b1101, carry_out=1, word_valid=1 for one cycle.
- word_ready=0: frame A=4'b0011, then frame B=4'b1010, then 2 more bits → A held; B held in FULL; the 2 extra bits each pulse overrun. Raise word_ready → A accepted, then B=4'b1010 presented with no gap.
- Mid-frame restart: sof, 2 bits, then sof with bits 0,1,1,0 → frame_err pulses once; word_out=4'b0110.
- IDLE bit_valid without sof → frame_err pulses; word_valid stays 0; the next proper frame assembles correctly.
- rst asserted asynchronously after bit 2 of a frame, then released → all outputs 0 immediately; the next full frame produces the correct word.
- With ADDAC_COLLECTOR_ERRCNT_EN defined: 3 framing errors + 2 overruns → err_count=5. err_clr → 0. 300 errors → saturates at 255.

Source files
------------

// File: rtl/addac_collector.sv
// addac_collector: deserialises the LSB-first serial sum stream of the
// add/accumulate cell into a WIDTH-bit word plus final carry, presented on a
// valid/ready output port. One word can wait in the shift register (FULL)
// while another waits in the output register, so the serial producer keeps
// going while the consumer stalls.
//
// Optional build macro ADDAC_COLLECTOR_ERRCNT_EN adds a saturating 8-bit error
// counter (err_count) with a synchronous clear input (err_clr).
//
// Output handshake: a result transfers on every rising edge where
// word_valid && word_ready; while word_valid=1 and word_ready=0 the values on
// word_out/carry_out do not change, and word_valid never drops without an
// acceptance.
module addac_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_sof,
    input  logic             s_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] word_out,
    output logic             carry_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             overrun,
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
    input  logic             err_clr,
    output logic [7:0]       err_count,
`endif
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             hold_carry, hold_carry_d;

    logic             accept, out_free;
    logic             start_bit, cont_bit, capturing, last_bit;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] asm_word;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             load_carry;
    logic             frame_err_d, overrun_d;

    assign fsm_state = state;

    // The output register can take a new word if empty or being emptied now.
    assign accept   = word_valid && word_ready;
    assign out_free = !word_valid || word_ready;

    // A start-of-frame bit always opens a fresh frame unless a word is parked.
    assign start_bit = bit_valid && bit_sof && ((state == IDLE) || (state == COLLECT));
    assign cont_bit  = bit_valid && !bit_sof && (state == COLLECT);
    assign capturing = start_bit || cont_bit;
    assign bit_idx   = start_bit ? '0 : cnt;
    assign last_bit  = capturing && (bit_idx == LAST);

    // Framing error: stray bit outside a frame, or a restart inside one.
    assign frame_err_d = bit_valid && (((state == IDLE) && !bit_sof) ||
                                       ((state == COLLECT) && bit_sof));
    // Overrun: any bit offered while a completed word is parked.
    assign overrun_d   = bit_valid && (state == FULL);

    // Word as it will look after this cycle's capture (fresh frame starts clean).
    always_comb begin
        asm_word = start_bit ? '0 : shreg;
        if (capturing) begin
            asm_word[bit_idx] = s_in;
        end
    end

    // Next-state, counter, shift register and output-load decisions.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        shreg_d      = shreg;
        hold_carry_d = hold_carry;
        load         = 1'b0;
        load_word    = shreg;
        load_carry   = hold_carry;
        if (capturing) begin
            shreg_d = asm_word;
            if (last_bit) begin
                cnt_d = '0;
                if (out_free) begin
                    load       = 1'b1;
                    load_word  = asm_word;
                    load_carry = cout_in;
                    state_d    = IDLE;
                end else begin
                    // Park the finished word here until the output frees up.
                    hold_carry_d = cout_in;
                    state_d      = FULL;
                end
            end else begin
                cnt_d   = bit_idx + CW'(1);
                state_d = COLLECT;
            end
        end else if (state == FULL) begin
            if (accept) begin
                // Parked word moves straight in behind the accepted one.
                load    = 1'b1;
                state_d = IDLE;
            end
        end else if ((state != IDLE) && (state != COLLECT)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Collector state: FSM, bit counter, shift register, parked carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            hold_carry <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            shreg      <= shreg_d;
            hold_carry <= hold_carry_d;
        end
    end

    // Output register: load a finished word, or drop valid once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out   <= '0;
            carry_out  <= 1'b0;
            word_valid <= 1'b0;
        end else if (load) begin
            word_out   <= load_word;
            carry_out  <= load_carry;
            word_valid <= 1'b1;
        end else if (accept) begin
            word_valid <= 1'b0;
        end
    end

    // Error pulses, registered so each lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

`ifdef ADDAC_COLLECTOR_ERRCNT_EN
    // Saturating error counter; clear takes priority over a same-cycle error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= 8'd0;
        end else if ((frame_err_d || overrun_d) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addac_collector.sv
// Bench for addac_collector (WIDTH=4): directed scenarios plus random traffic,
// checked every cycle against a frame/queue level model of the collector.
module tb_addac_collector;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_valid, bit_sof, s_in, cout_in, word_ready;
    logic [WIDTH-1:0] word_out;
    logic             carry_out, word_valid, frame_err, overrun;
    logic [1:0]       fsm_state;
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
    logic             err_clr = 1'b0;
    logic [7:0]       err_count;
    int               m_cnt;
`endif

    int n_vec = 0;
    int n_mis = 0;

    // Model state: bits of the frame in progress, output slot, parked word.
    bit               frame_q[$];
    bit               m_valid, m_carry, m_fe, m_ov, m_full, m_hcarry;
    logic [WIDTH-1:0] m_word, m_hword;

    addac_collector #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_sof    (bit_sof),
        .s_in       (s_in),
        .cout_in    (cout_in),
        .word_out   (word_out),
        .carry_out  (carry_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
        .err_clr    (err_clr),
        .err_count  (err_count),
`endif
        .fsm_state  (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_valid  = 1'b0;
        m_carry  = 1'b0;
        m_word   = '0;
        m_fe     = 1'b0;
        m_ov     = 1'b0;
        m_full   = 1'b0;
        m_hword  = '0;
        m_hcarry = 1'b0;
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
        m_cnt = 0;
`endif
    endtask

    // One clock edge of behaviour, from the inputs present at that edge.
    task automatic model_step(input bit bv, input bit sof, input bit s, input bit c, input bit rdy);
        bit               acc, ld, fe, ov, lc;
        logic [WIDTH-1:0] lw;
        acc = m_valid && rdy;
        ld  = 1'b0;
        fe  = 1'b0;
        ov  = 1'b0;
        lc  = 1'b0;
        lw  = '0;
        if (m_full) begin
            if (bv) ov = 1'b1;
            if (acc) begin
                ld = 1'b1; lw = m_hword; lc = m_hcarry; m_full = 1'b0;
            end
        end else if (bv) begin
            if (sof) begin
                if (frame_q.size() != 0) fe = 1'b1;
                frame_q.delete();
                frame_q.push_back(s);
            end else if (frame_q.size() == 0) begin
                fe = 1'b1;
            end else begin
                frame_q.push_back(s);
            end
            if (frame_q.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) lw[i] = frame_q[i];
                lc = c;
                frame_q.delete();
                if (!m_valid || rdy) ld = 1'b1;
                else begin
                    m_full = 1'b1; m_hword = lw; m_hcarry = lc;
                end
            end
        end
        if (ld) begin
            m_valid = 1'b1; m_word = lw; m_carry = lc;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        m_fe = fe;
        m_ov = ov;
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
        if (err_clr) m_cnt = 0;
        else if ((fe || ov) && m_cnt < 255) m_cnt++;
`endif
    endtask

    task automatic compare_all();
        check("word_valid", word_valid, m_valid);
        check("frame_err", frame_err, m_fe);
        check("overrun", overrun, m_ov);
        if (m_valid) begin
            check("word_out", word_out, m_word);
            check("carry_out", carry_out, m_carry);
        end
`ifdef ADDAC_COLLECTOR_ERRCNT_EN
        check("err_count", err_count, m_cnt);
`endif
    endtask

    // Driver: present inputs after a falling edge, step model at the rising
    // edge, compare at the next falling edge.
    task automatic cycle(input bit bv, input bit sof, input bit s, input bit c, input bit rdy);
        bit_valid  = bv;
        bit_sof    = sof;
        s_in       = s;
        cout_in    = c;
        word_ready = rdy;
        @(posedge clk);
        model_step(bv, sof, s, c, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit c, input bit rdy);
        for (int i = 0; i < WIDTH; i++) begin
            cycle(1'b1, i == 0, w[i], (i == WIDTH - 1) ? c : 1'($urandom_range(0, 1)), rdy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_valid"}, word_valid, 1'b0);
        check({tag, "_word_out"}, word_out, '0);
        check({tag, "_carry_out"}, carry_out, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bit_valid = 0; bit_sof = 0; s_in = 0; cout_in = 0; word_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic frame, consumer ready.
        send_frame(4'b1101, 1'b1, 1'b1);
        check("t1_word", word_out, 4'b1101);
        check("t1_carry", carry_out, 1'b1);
        check("t1_valid", word_valid, 1'b1);
        cycle(0, 0, 0, 0, 1);
        check("t1_valid_drop", word_valid, 1'b0);

        // Stalled consumer: A held in output, B parked, two bits dropped.
        send_frame(4'b0011, 1'b0, 1'b0);
        send_frame(4'b1010, 1'b1, 1'b0);
        cycle(1, 1, 1, 0, 0);
        check("t2_overrun1", overrun, 1'b1);
        cycle(1, 0, 0, 0, 0);
        check("t2_overrun2", overrun, 1'b1);
        check("t2_a_stable", word_out, 4'b0011);
        cycle(0, 0, 0, 0, 1);
        check("t2_b_word", word_out, 4'b1010);
        check("t2_b_carry", carry_out, 1'b1);
        check("t2_b_valid", word_valid, 1'b1);
        cycle(0, 0, 0, 0, 1);
        check("t2_drained", word_valid, 1'b0);

        // Mid-frame restart.
        cycle(1, 1, 1, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        check("t3_frame_err", frame_err, 1'b1);
        cycle(1, 0, 1, 0, 1);
        check("t3_err_once", frame_err, 1'b0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 0, 0, 1, 1);
        check("t3_word", word_out, 4'b0110);
        check("t3_carry", carry_out, 1'b1);

        // Stray bit in IDLE, then a proper frame.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 1);
        check("t4_frame_err", frame_err, 1'b1);
        check("t4_no_valid", word_valid, 1'b0);
        send_frame(4'b1001, 1'b0, 1'b1);
        check("t4_word", word_out, 4'b1001);

        // Asynchronous reset mid-frame with a word held.
        send_frame(4'b0101, 1'b1, 1'b0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_frame(4'b1110, 1'b0, 1'b1);
        check("t5_word", word_out, 4'b1110);
        check("t5_valid", word_valid, 1'b1);

`ifdef ADDAC_COLLECTOR_ERRCNT_EN
        cycle(0, 0, 0, 0, 1);
        err_clr = 1'b1;
        cycle(0, 0, 0, 0, 1);
        err_clr = 1'b0;
        check("cnt_clr0", err_count, 8'd0);
        repeat (3) cycle(1, 0, 0, 0, 1);
        send_frame(4'b0001, 1'b0, 1'b0);
        send_frame(4'b0010, 1'b0, 1'b0);
        repeat (2) cycle(1, 0, 0, 0, 0);
        check("cnt_five", err_count, 8'd5);
        repeat (2) cycle(0, 0, 0, 0, 1);
        err_clr = 1'b1;
        cycle(0, 0, 0, 0, 1);
        err_clr = 1'b0;
        check("cnt_clr1", err_count, 8'd0);
        repeat (300) cycle(1, 0, 0, 0, 1);
        check("cnt_sat", err_count, 8'd255);
`endif

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bit bv, sof;
            bv  = ($urandom_range(0, 99) < 60);
            sof = bv && ($urandom_range(0, 99) < 22);
            cycle(bv, sof, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 65);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
